ssf_lane_scheduler: RTL

Sequencer and output arbiter for a bank of parallel `ssf` lanes sharing one input stream. It releases the lanes from reset one after another at a fixed stagger interval. It then arbitrates the lanes' `out_en`/`io_out` results onto a single output port with registered round-robin fairness, and merges their `req_in` requests. It sits between the lane bank and the host-side bus, replacing fixed-priority muxing and free-running reset sequencing.

---
 rtl/ssf_lane_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ssf_lane_scheduler.sv
// ssf_lane_scheduler: staggered reset release and round-robin output arbiter
// for a bank of ssf lanes sharing one input stream.
//
// Optional feature: define SSF_SCHED_COLLISION_CNT_EN to build the saturating
// lost-result counter on `collisions`; otherwise the port is tied to zero.
//
// The arbiter runs in every state but only looks at released lanes. The
// round-robin pointer holds the last granted lane; the search starts one past it.
module ssf_lane_scheduler #(
  parameter int N_LANES = 39,
  parameter int STAGGER = 824,
  parameter int DW      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic [N_LANES-1:0]      lane_rst,
  input  logic [2*N_LANES-1:0]    lane_req_in,
  input  logic [2*N_LANES-1:0]    lane_out_en,
  input  logic [DW*N_LANES-1:0]   lane_io_out,
  output logic [DW-1:0]           io_out,
  output logic [1:0]              out_en,
  output logic [1:0]              req_in,
  output logic [5:0]              grant_id,
  output logic                    busy,
  output logic [15:0]             collisions
);

  localparam int CW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STAGGER, S_RUN} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [6:0]           next_lane, next_lane_n;
  logic [N_LANES-1:0]   lane_rst_n;

  logic [N_LANES-1:0]   act;
  logic [N_LANES-1:0]   reqv;
  logic [N_LANES-1:0]   hi_act;
  logic [5:0]           rr_ptr;
  logic [5:0]           gidx, gidx_hi, gidx_lo;
  logic                 found;
  logic [DW-1:0]        gdata;

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      next_lane <= '0;
      lane_rst  <= '1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      next_lane <= next_lane_n;
      lane_rst  <= lane_rst_n;
    end
  end

  // Sequencer next-state: stop wins over everything, start only counts in IDLE
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    next_lane_n = next_lane;
    lane_rst_n  = lane_rst;
    if (stop) begin
      state_n     = S_IDLE;
      cnt_n       = '0;
      next_lane_n = '0;
      lane_rst_n  = '1;
    end else begin
      case (state)
        S_IDLE: begin
          lane_rst_n = '1;
          if (start) begin
            state_n       = S_STAGGER;
            cnt_n         = '0;
            next_lane_n   = 7'd1;
            lane_rst_n[0] = 1'b0;
          end
        end
        S_STAGGER: begin
          if (cnt == CW'(STAGGER - 1)) begin
            cnt_n       = '0;
            next_lane_n = next_lane + 7'd1;
            for (int k = 0; k < N_LANES; k++) begin
              if (int'(next_lane) == k) lane_rst_n[k] = 1'b0;
            end
            if (int'(next_lane) == N_LANES - 1) state_n = S_RUN;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RUN: begin
          state_n = S_RUN;
        end
        default: begin
          state_n    = S_IDLE;
          lane_rst_n = '1;
        end
      endcase
    end
  end

  assign busy = (state == S_STAGGER);

  // Per-lane active/request qualification; lanes still in reset are ignored
  always_comb begin
    act  = '0;
    reqv = '0;
    for (int k = 0; k < N_LANES; k++) begin
      act[k]  = !lane_rst[k] && (lane_out_en[2*k +: 2] == 2'b01);
      reqv[k] = !lane_rst[k] && (lane_req_in[2*k +: 2] == 2'b01);
    end
  end

  // Round-robin pick: lowest active lane above the pointer, else lowest overall
  always_comb begin
    hi_act  = '0;
    gidx_hi = '0;
    gidx_lo = '0;
    for (int k = 0; k < N_LANES; k++) begin
      hi_act[k] = act[k] && (k > int'(rr_ptr));
    end
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (hi_act[k]) gidx_hi = 6'(k);
      if (act[k])    gidx_lo = 6'(k);
    end
    found = |act;
    gidx  = (|hi_act) ? gidx_hi : gidx_lo;
  end

  // Data mux for the granted lane
  always_comb begin
    gdata = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (gidx == 6'(k)) gdata = lane_io_out[DW*k +: DW];
    end
  end

  // Registered arbiter outputs and pointer; pointer returns to 0 on stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      io_out   <= '0;
      out_en   <= 2'b00;
      req_in   <= 2'b00;
      grant_id <= '0;
    end else begin
      if (stop)       rr_ptr <= '0;
      else if (found) rr_ptr <= gidx;
      io_out <= found ? gdata : '0;
      out_en <= {1'b0, found};
      if (found) grant_id <= gidx;
      req_in <= {1'b0, |reqv};
    end
  end

`ifdef SSF_SCHED_COLLISION_CNT_EN
  logic [6:0]  act_cnt;
  logic [16:0] coll_sum;

  // Count active released lanes this cycle
  always_comb begin
    act_cnt = '0;
    for (int k = 0; k < N_LANES; k++) begin
      act_cnt = act_cnt + 7'(act[k]);
    end
  end

  assign coll_sum = {1'b0, collisions} + 17'(act_cnt) - 17'd1;

  // Every active lane beyond the winner loses its result; saturate at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collisions <= '0;
    end else if (state == S_IDLE && start && !stop) begin
      collisions <= '0;
    end else if (act_cnt >= 7'd2) begin
      collisions <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
    end
  end
`else
  assign collisions = 16'h0000;
`endif

endmodule
